// File: rtl/autoconfig_host_if.sv
// Zorro II autoconfig bus seen from the host: nibble data path, strobes and the config chain enable.
interface autoconfig_host_if;
  logic [22:0] ADDR;
  logic        AS_n;
  logic        RW;
  logic [3:0]  DOUT;
  logic [3:0]  DIN;
  logic        DTACK;
  logic        CFGOUT_n;

  modport master (output ADDR, AS_n, RW, DOUT, CFGOUT_n, input DIN, DTACK);
  modport slave  (input ADDR, AS_n, RW, DOUT, CFGOUT_n, output DIN, DTACK);
endinterface

// File: rtl/autoconfig_host.sv
// Zorro II autoconfig initiator: walks the config chain, reads each board's nibble registers,
// places it in the Fast RAM or I/O pool (or shuts it up) and reports what it found.
module autoconfig_host #(
  parameter int         TIMEOUT    = 63,
  parameter int         MAX_BOARDS = 8,
  parameter logic [7:0] MEM_BASE   = 8'h20,
  parameter logic [7:0] IO_BASE    = 8'hE9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  autoconfig_host_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        board_count,
  output logic              rpt_valid,
  output logic [15:0]       rpt_mfg,
  output logic [7:0]        rpt_prod,
  output logic [31:0]       rpt_serial,
  output logic [7:0]        rpt_base,
  output logic [2:0]        rpt_size,
  output logic              rpt_shutup
);

  localparam int         CW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MEM_END  = 8'h9F;
  localparam logic [7:0] IO_END   = 8'hEF;
  localparam logic [4:0] LAST_IDX = 5'd17;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_SETUP   = 4'd1;
  localparam logic [3:0] S_ASSERT  = 4'd2;
  localparam logic [3:0] S_WAIT    = 4'd3;
  localparam logic [3:0] S_RELEASE = 4'd4;
  localparam logic [3:0] S_GAP     = 4'd5;
  localparam logic [3:0] S_DECIDE  = 4'd6;
  localparam logic [3:0] S_REPORT  = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam logic [1:0] P_READ = 2'd0;
  localparam logic [1:0] P_WR25 = 2'd1;
  localparam logic [1:0] P_WR24 = 2'd2;
  localparam logic [1:0] P_WR26 = 2'd3;

  logic [3:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tout_q, tout_d;
  logic [7:0]    mem_ptr_q, mem_ptr_d, io_ptr_q, io_ptr_d;
  logic [7:0]    base_q, base_d;
  logic          shut_q, shut_d;
  logic          err_q, err_d;
  logic [3:0]    count_q, count_d;
  logic [15:0]   rpt_mfg_q, rpt_mfg_d;
  logic [7:0]    rpt_prod_q, rpt_prod_d;
  logic [31:0]   rpt_serial_q, rpt_serial_d;
  logic [7:0]    rpt_base_q, rpt_base_d;
  logic [2:0]    rpt_size_q, rpt_size_d;
  logic          rpt_shut_q, rpt_shut_d;

  // Nibble register file indexed by the card's register number ($00..$13).
  logic [3:0]    nib_q [0:19];

  logic [7:0] reg_addr;
  logic [3:0] wr_nib;
  logic       in_cycle;

  always_comb begin
    reg_addr = 8'h00;
    wr_nib   = 4'h0;
    case (phase_q)
      P_READ:  reg_addr = (idx_q < 5'd6) ? {3'b000, idx_q} : {3'b000, idx_q + 5'd2};
      P_WR25:  begin reg_addr = 8'h25; wr_nib = base_q[3:0]; end
      P_WR24:  begin reg_addr = 8'h24; wr_nib = base_q[7:4]; end
      default: reg_addr = 8'h26;
    endcase
  end

  assign in_cycle     = (state_q == S_SETUP) || (state_q == S_ASSERT) ||
                        (state_q == S_WAIT)  || (state_q == S_RELEASE);
  assign bus.ADDR     = in_cycle ? {8'hE8, 7'd0, reg_addr} : 23'd0;
  assign bus.AS_n     = !((state_q == S_ASSERT) || (state_q == S_WAIT));
  assign bus.RW       = !(in_cycle && (phase_q != P_READ));
  assign bus.DOUT     = in_cycle ? wr_nib : 4'h0;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.CFGOUT_n = !busy;
  assign done         = (state_q == S_DONE);
  assign rpt_valid    = (state_q == S_REPORT);
  assign err          = err_q;
  assign board_count  = count_q;
  assign rpt_mfg      = rpt_mfg_q;
  assign rpt_prod     = rpt_prod_q;
  assign rpt_serial   = rpt_serial_q;
  assign rpt_base     = rpt_base_q;
  assign rpt_size     = rpt_size_q;
  assign rpt_shutup   = rpt_shut_q;

  // Placement in 64K units. An 8MB board can only ever start the Zorro II memory window,
  // so it aligns on the 2MB window granularity instead of its own size.
  logic [2:0] size_code;
  logic       is_mem;
  logic [8:0] size9, align9, ptr9, base9, last9;
  logic       fit;

  always_comb begin
    size_code = nib_q[1][2:0];
    is_mem    = nib_q[0][1];
    size9     = (size_code == 3'd0) ? 9'd128 : (9'd1 << (size_code - 3'd1));
    align9    = (size_code == 3'd0) ? 9'd32 : size9;
    ptr9      = {1'b0, is_mem ? mem_ptr_q : io_ptr_q};
    base9     = (ptr9 + align9 - 9'd1) & ~(align9 - 9'd1);
    last9     = base9 + size9 - 9'd1;
    fit       = last9 <= {1'b0, is_mem ? MEM_END : IO_END};
  end

  always_comb begin
    state_d = state_q;  phase_d = phase_q;  idx_d = idx_q;  cnt_d = cnt_q;  tout_d = tout_q;
    mem_ptr_d = mem_ptr_q;  io_ptr_d = io_ptr_q;  base_d = base_q;  shut_d = shut_q;
    err_d = err_q;  count_d = count_q;
    rpt_mfg_d = rpt_mfg_q;  rpt_prod_d = rpt_prod_q;  rpt_serial_d = rpt_serial_q;
    rpt_base_d = rpt_base_q;  rpt_size_d = rpt_size_q;  rpt_shut_d = rpt_shut_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_SETUP;  phase_d = P_READ;  idx_d = 5'd0;
        mem_ptr_d = MEM_BASE;  io_ptr_d = IO_BASE;  count_d = 4'd0;  err_d = 1'b0;
      end
      S_SETUP:  begin state_d = S_ASSERT; cnt_d = '0; tout_d = 1'b0; end
      S_ASSERT: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.DTACK) begin
          state_d = S_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = S_RELEASE;
          tout_d  = 1'b1;
          if (phase_q != P_READ) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_GAP;
      S_GAP: begin
        case (phase_q)
          P_READ: begin
            if (tout_q && idx_q == 5'd0) begin
              state_d = S_DONE;
            end else if (tout_q) begin
              state_d = S_SETUP;  phase_d = P_WR26;  base_d = 8'h00;  shut_d = 1'b1;
            end else if (idx_q == LAST_IDX) begin
              state_d = S_DECIDE;
            end else begin
              state_d = S_SETUP;  idx_d = idx_q + 5'd1;
            end
          end
          P_WR25: begin state_d = S_SETUP; phase_d = P_WR24; end
          default: begin
            state_d      = S_REPORT;
            count_d      = count_q + 4'd1;
            rpt_mfg_d    = {nib_q[8], nib_q[9], nib_q[10], nib_q[11]};
            rpt_prod_d   = {nib_q[2], nib_q[3]};
            rpt_serial_d = {nib_q[12], nib_q[13], nib_q[14], nib_q[15],
                            nib_q[16], nib_q[17], nib_q[18], nib_q[19]};
            rpt_base_d   = base_q;
            rpt_size_d   = nib_q[1][2:0];
            rpt_shut_d   = shut_q;
          end
        endcase
      end
      S_DECIDE: begin
        state_d = S_SETUP;
        if (fit) begin
          phase_d = P_WR25;  base_d = base9[7:0];  shut_d = 1'b0;
          if (is_mem) mem_ptr_d = base9[7:0] + size9[7:0];
          else        io_ptr_d  = base9[7:0] + size9[7:0];
        end else begin
          phase_d = P_WR26;  base_d = 8'h00;  shut_d = 1'b1;
        end
      end
      S_REPORT: begin
        if (count_q == 4'(MAX_BOARDS)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;  phase_d = P_READ;  idx_d = 5'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Only $00/$01 arrive true; every other autoconfig register reads back inverted.
  always_ff @(posedge CLK) begin
    if (state_q == S_WAIT && bus.DTACK && phase_q == P_READ)
      nib_q[reg_addr[4:0]] <= (idx_q < 5'd2) ? bus.DIN : ~bus.DIN;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;  phase_q <= P_READ;  idx_q <= 5'd0;  cnt_q <= '0;  tout_q <= 1'b0;
      mem_ptr_q <= MEM_BASE;  io_ptr_q <= IO_BASE;  base_q <= 8'h00;  shut_q <= 1'b0;
      err_q <= 1'b0;  count_q <= 4'd0;
      rpt_mfg_q <= 16'h0;  rpt_prod_q <= 8'h0;  rpt_serial_q <= 32'h0;
      rpt_base_q <= 8'h0;  rpt_size_q <= 3'd0;  rpt_shut_q <= 1'b0;
    end else begin
      state_q <= state_d;  phase_q <= phase_d;  idx_q <= idx_d;  cnt_q <= cnt_d;  tout_q <= tout_d;
      mem_ptr_q <= mem_ptr_d;  io_ptr_q <= io_ptr_d;  base_q <= base_d;  shut_q <= shut_d;
      err_q <= err_d;  count_q <= count_d;
      rpt_mfg_q <= rpt_mfg_d;  rpt_prod_q <= rpt_prod_d;  rpt_serial_q <= rpt_serial_d;
      rpt_base_q <= rpt_base_d;  rpt_size_q <= rpt_size_d;  rpt_shut_q <= rpt_shut_d;
    end
  end

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a chain of behavioural autoconfig cards answers the host, and a
// byte-address placement model predicts every report.
module tb_autoconfig_host;
  localparam int NC      = 10;
  localparam int TIMEOUT = 63;

  logic        CLK = 1'b0;
  logic        RESET, start;
  logic        busy, done, err, rpt_valid, rpt_shutup;
  logic [3:0]  board_count;
  logic [15:0] rpt_mfg;
  logic [7:0]  rpt_prod, rpt_base;
  logic [31:0] rpt_serial;
  logic [2:0]  rpt_size;

  always #5 CLK = ~CLK;

  autoconfig_host_if bus();

  autoconfig_host #(.TIMEOUT(TIMEOUT), .MAX_BOARDS(8), .MEM_BASE(8'h20), .IO_BASE(8'hE9)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .bus(bus),
    .busy(busy), .done(done), .err(err), .board_count(board_count),
    .rpt_valid(rpt_valid), .rpt_mfg(rpt_mfg), .rpt_prod(rpt_prod), .rpt_serial(rpt_serial),
    .rpt_base(rpt_base), .rpt_size(rpt_size), .rpt_shutup(rpt_shutup)
  );

  int tests = 0;
  int fails = 0;

  // Card chain definition and per-card state (0 unconfigured, 1 configured, 2 shut up).
  logic [15:0] c_mfg [NC];
  logic [7:0]  c_prod [NC];
  logic [31:0] c_serial [NC];
  logic        c_mem [NC];
  logic [2:0]  c_code [NC];
  logic        c_hold [NC];
  int          c_cut [NC];
  int          c_st [NC];
  logic [3:0]  c_lo [NC];
  logic [7:0]  c_base [NC];
  int          n_cards;

  logic [15:0] r_mfg [$];
  logic [7:0]  r_prod [$];
  logic [31:0] r_serial [$];
  logic [7:0]  r_base [$];
  logic [2:0]  r_size [$];
  logic        r_shut [$];

  logic [7:0]  e_base [NC];
  logic        e_shut [NC];
  int          e_n;
  logic        e_err;

  int low_len = 0, held_len = 0, dly = 0, resp_a, resp_r;
  bit acked = 0, held_flag = 0;

  function automatic int active_card();
    for (int i = 0; i < n_cards; i++) if (c_st[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [3:0] card_nib(int a, int r);
    logic [31:0] s;
    case (r)
      0:  return {2'b11, c_mem[a], 1'b0};
      1:  return {1'b0, c_code[a]};
      2:  return ~c_prod[a][7:4];
      3:  return ~c_prod[a][3:0];
      8:  return ~c_mfg[a][15:12];
      9:  return ~c_mfg[a][11:8];
      10: return ~c_mfg[a][7:4];
      11: return ~c_mfg[a][3:0];
      default: begin
        if (r >= 12 && r <= 19) begin
          s = c_serial[a] >> (4 * (19 - r));
          return ~s[3:0];
        end
        return 4'hF;
      end
    endcase
  endfunction

  // Card responder: answers after 0..3 clocks; a withheld $24 write still configures the card.
  always @(negedge CLK) begin
    if (bus.AS_n !== 1'b0) begin
      if (held_flag) begin held_len = low_len; held_flag = 0; end
      low_len = 0; acked = 0; bus.DTACK = 1'b0; dly = $urandom_range(0, 3);
    end else begin
      low_len++;
      if (!acked && dly > 0) dly--;
      else if (!acked) begin
        acked  = 1;
        resp_a = (bus.CFGOUT_n == 1'b0 && bus.ADDR[22:15] == 8'hE8) ? active_card() : -1;
        resp_r = int'(bus.ADDR[7:0]);
        if (resp_a >= 0) begin
          if (bus.RW) begin
            if (resp_r != c_cut[resp_a]) begin
              bus.DIN = card_nib(resp_a, resp_r); bus.DTACK = 1'b1;
            end
          end else begin
            if (resp_r == 'h25) c_lo[resp_a] = bus.DOUT;
            else if (resp_r == 'h24) begin c_base[resp_a] = {bus.DOUT, c_lo[resp_a]}; c_st[resp_a] = 1; end
            else if (resp_r == 'h26) c_st[resp_a] = 2;
            if (resp_r == 'h24 && c_hold[resp_a]) held_flag = 1;
            else bus.DTACK = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (rpt_valid === 1'b1) begin
      r_mfg.push_back(rpt_mfg); r_prod.push_back(rpt_prod); r_serial.push_back(rpt_serial);
      r_base.push_back(rpt_base); r_size.push_back(rpt_size); r_shut.push_back(rpt_shutup);
      $display("[TB] report mfg=%h prod=%h serial=%h base=%h size=%0d shutup=%0b",
               rpt_mfg, rpt_prod, rpt_serial, rpt_base, rpt_size, rpt_shutup);
    end
  end

  task automatic clear_cards();
    n_cards = 0;
    for (int i = 0; i < NC; i++) begin c_hold[i] = 0; c_cut[i] = -1; end
  endtask

  task automatic set_card(input int i, input logic [15:0] m, input logic [7:0] p,
                          input logic [31:0] s, input logic mem, input logic [2:0] code);
    c_mfg[i] = m; c_prod[i] = p; c_serial[i] = s; c_mem[i] = mem; c_code[i] = code;
    c_hold[i] = 0; c_cut[i] = -1;
    if (n_cards < i + 1) n_cards = i + 1;
  endtask

  task automatic start_pass();
    for (int i = 0; i < NC; i++) begin c_st[i] = 0; c_lo[i] = 4'h0; c_base[i] = 8'h00; end
    r_mfg.delete(); r_prod.delete(); r_serial.delete(); r_base.delete(); r_size.delete(); r_shut.delete();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin seen = 1; break; end
    end
    if (!seen) begin $display("FAIL pass_done: done=0 after 20000 cycles, required 1"); fails++; end
    tests++;
  endtask

  // Reference placement in byte addresses: align up, fit inside the pool, bump the pointer.
  task automatic model_pass();
    longint mp = 64'h200000, ip = 64'hE90000, p, lim, size, align, b;
    e_n = 0; e_err = 0;
    for (int i = 0; i < n_cards; i++) begin
      if (e_n == 8 || c_cut[i] == 0) break;
      e_shut[i] = 1; e_base[i] = 8'h00;
      if (c_cut[i] < 0) begin
        size  = (c_code[i] == 0) ? (64'd1 << 23) : (64'd1 << (15 + c_code[i]));
        align = (c_code[i] == 0) ? (64'd1 << 21) : size;
        p     = c_mem[i] ? mp : ip;
        lim   = c_mem[i] ? 64'hA00000 : 64'hF00000;
        b     = ((p + align - 1) / align) * align;
        if (b + size <= lim) begin
          e_shut[i] = 0; e_base[i] = 8'(b >> 16);
          if (c_mem[i]) mp = b + size; else ip = b + size;
          if (c_hold[i]) e_err = 1;
        end
      end
      e_n++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 1'b0;
    repeat (3) @(negedge CLK);
    if ({bus.AS_n, bus.RW, bus.CFGOUT_n} !== 3'b111) begin $display("FAIL reset_strobes: AS_n/RW/CFGOUT_n=%b required 111", {bus.AS_n, bus.RW, bus.CFGOUT_n}); fails++; end tests++;
    if (bus.ADDR !== 23'd0 || bus.DOUT !== 4'h0) begin $display("FAIL reset_bus: ADDR=%h DOUT=%h required 0/0", bus.ADDR, bus.DOUT); fails++; end tests++;
    if ({busy, done, err, rpt_valid} !== 4'b0000) begin $display("FAIL reset_status: busy/done/err/valid=%b required 0000", {busy, done, err, rpt_valid}); fails++; end tests++;
    if (board_count !== 4'd0 || rpt_base !== 8'h00 || rpt_mfg !== 16'h0) begin $display("FAIL reset_rpt: count=%0d base=%h mfg=%h required 0", board_count, rpt_base, rpt_mfg); fails++; end tests++;
    RESET = 1'b0;
  endtask

  task automatic test_single_mem();
    clear_cards(); set_card(0, 16'h07DB, 8'd72, 32'd421, 1'b1, 3'd0);
    start_pass(); wait_done();
    if (r_base.size() !== 1) begin $display("FAIL t1_reports: got %0d required 1", r_base.size()); fails++; end tests++;
    if (r_mfg[0] !== 16'h07DB || r_prod[0] !== 8'd72 || r_serial[0] !== 32'd421) begin $display("FAIL t1_ids: mfg=%h prod=%0d serial=%0d required 07db/72/421", r_mfg[0], r_prod[0], r_serial[0]); fails++; end tests++;
    if (r_base[0] !== 8'h20 || r_size[0] !== 3'd0 || r_shut[0] !== 1'b0) begin $display("FAIL t1_place: base=%h size=%0d shut=%0b required 20/0/0", r_base[0], r_size[0], r_shut[0]); fails++; end tests++;
    if (c_lo[0] !== 4'h0 || c_base[0] !== 8'h20 || c_st[0] !== 1) begin $display("FAIL t1_card_writes: lo=%h base=%h st=%0d required 0/20/1", c_lo[0], c_base[0], c_st[0]); fails++; end tests++;
    if (board_count !== 4'd1) begin $display("FAIL t1_count: got %0d required 1", board_count); fails++; end tests++;
  endtask

  task automatic test_io_chain();
    clear_cards(); set_card(0, 16'h07DB, 8'd72, 32'd421, 1'b1, 3'd0);
    set_card(1, 16'h1234, 8'h10, 32'hA5A5_0001, 1'b0, 3'd1);
    set_card(2, 16'h5678, 8'h11, 32'h0000_BEEF, 1'b0, 3'd1);
    start_pass(); wait_done();
    if (busy !== 1'b0 || bus.CFGOUT_n !== 1'b1) begin $display("FAIL t2_done_state: busy=%b CFGOUT_n=%b required 0/1", busy, bus.CFGOUT_n); fails++; end tests++;
    if (r_base.size() !== 3 || r_base[0] !== 8'h20 || r_base[1] !== 8'hE9 || r_base[2] !== 8'hEA) begin $display("FAIL t2_bases: n=%0d %h %h %h required 3 20 e9 ea", r_base.size(), r_base[0], r_base[1], r_base[2]); fails++; end tests++;
    if (board_count !== 4'd3 || err !== 1'b0) begin $display("FAIL t2_status: count=%0d err=%b required 3/0", board_count, err); fails++; end tests++;
    if (r_mfg[2] !== 16'h5678 || r_serial[1] !== 32'hA5A5_0001) begin $display("FAIL t2_ids: mfg2=%h serial1=%h required 5678/a5a50001", r_mfg[2], r_serial[1]); fails++; end tests++;
    @(negedge CLK);
    if (done !== 1'b0) begin $display("FAIL t2_done_pulse: done=%b one clock later, required 0", done); fails++; end tests++;
  endtask

  task automatic test_no_fit();
    clear_cards(); set_card(0, 16'h0001, 8'h01, 32'd1, 1'b1, 3'd0);
    set_card(1, 16'h0002, 8'h02, 32'd2, 1'b1, 3'd0);
    start_pass(); wait_done();
    if (r_base[0] !== 8'h20 || r_base[1] !== 8'h00 || r_shut[1] !== 1'b1) begin $display("FAIL t3_nofit: base0=%h base1=%h shut1=%b required 20/00/1", r_base[0], r_base[1], r_shut[1]); fails++; end tests++;
    if (c_st[1] !== 2) begin $display("FAIL t3_shutup_write: card1 state=%0d required 2", c_st[1]); fails++; end tests++;
  endtask

  task automatic test_align();
    clear_cards(); set_card(0, 16'h0003, 8'h03, 32'd3, 1'b1, 3'd1);
    set_card(1, 16'h0004, 8'h04, 32'd4, 1'b1, 3'd7);
    start_pass(); wait_done();
    if (r_base[0] !== 8'h20 || r_base[1] !== 8'h40 || c_base[1] !== 8'h40) begin $display("FAIL t4_align: base0=%h base1=%h card1=%h required 20/40/40", r_base[0], r_base[1], c_base[1]); fails++; end tests++;
    if (r_size[1] !== 3'd7) begin $display("FAIL t4_size: got %0d required 7", r_size[1]); fails++; end tests++;
  endtask

  task automatic test_write_timeout();
    clear_cards(); set_card(0, 16'h0005, 8'h05, 32'd5, 1'b0, 3'd1);
    set_card(1, 16'h0006, 8'h06, 32'd6, 1'b0, 3'd1);
    c_hold[0] = 1; held_len = 0;
    start_pass(); wait_done();
    if (err !== 1'b1) begin $display("FAIL t5_err: got %b required 1", err); fails++; end tests++;
    if (held_len !== TIMEOUT + 2) begin $display("FAIL t5_strobe_len: AS_n low %0d clocks required %0d", held_len, TIMEOUT + 2); fails++; end tests++;
    if (board_count !== 4'd2 || r_base[1] !== 8'hEA) begin $display("FAIL t5_continue: count=%0d base1=%h required 2/ea", board_count, r_base[1]); fails++; end tests++;
  endtask

  task automatic test_reset_midcycle();
    bit hit = 0;
    clear_cards(); set_card(0, 16'h07DB, 8'd72, 32'd421, 1'b1, 3'd0);
    start_pass();
    if (err !== 1'b0) begin $display("FAIL t6_err_clear: err=%b after start, required 0", err); fails++; end tests++;
    for (int i = 0; i < 200; i++) begin
      if (bus.AS_n === 1'b0 && bus.RW === 1'b1) begin hit = 1; break; end
      @(negedge CLK);
    end
    @(negedge CLK);
    if (!hit || bus.AS_n !== 1'b0) begin $display("FAIL t6_reach_wait: read strobe seen=%0b AS_n=%b required 1/0", hit, bus.AS_n); fails++; end tests++;
    RESET = 1'b1;
    @(negedge CLK);
    if ({bus.AS_n, bus.CFGOUT_n, busy} !== 3'b110 || rpt_base !== 8'h00) begin $display("FAIL t6_abort: AS_n/CFGOUT_n/busy=%b rpt_base=%h required 110/00", {bus.AS_n, bus.CFGOUT_n, busy}, rpt_base); fails++; end tests++;
    RESET = 1'b0;
    start_pass(); wait_done();
    if (r_base.size() !== 1 || r_base[0] !== 8'h20 || board_count !== 4'd1) begin $display("FAIL t6_rerun: n=%0d base=%h count=%0d required 1/20/1", r_base.size(), r_base[0], board_count); fails++; end tests++;
  endtask

  task automatic test_random();
    int n, k;
    for (int it = 0; it < 6; it++) begin
      clear_cards();
      n = (it == 0) ? NC : int'($urandom_range(1, 9));
      for (int i = 0; i < n; i++) begin
        set_card(i, 16'($urandom), 8'($urandom), $urandom, 1'($urandom), 3'($urandom));
        c_hold[i] = ($urandom_range(0, 5) == 0);
        if (it != 0 && $urandom_range(0, 7) == 0) begin
          k = int'($urandom_range(0, 17));
          c_cut[i] = (k < 6) ? k : k + 2;
        end
      end
      model_pass();
      start_pass(); wait_done();
      if (r_base.size() !== e_n || board_count !== 4'(e_n)) begin $display("FAIL rnd%0d_count: reports=%0d count=%0d required %0d", it, r_base.size(), board_count, e_n); fails++; end tests++;
      if (err !== e_err) begin $display("FAIL rnd%0d_err: got %b required %b", it, err, e_err); fails++; end tests++;
      for (int i = 0; i < e_n && i < r_base.size(); i++) begin
        if (r_base[i] !== e_base[i] || r_shut[i] !== e_shut[i]) begin $display("FAIL rnd%0d_place%0d: base=%h shut=%b required %h/%b", it, i, r_base[i], r_shut[i], e_base[i], e_shut[i]); fails++; end tests++;
        if (c_cut[i] < 0 && (r_mfg[i] !== c_mfg[i] || r_prod[i] !== c_prod[i] || r_serial[i] !== c_serial[i] || r_size[i] !== c_code[i])) begin
          $display("FAIL rnd%0d_ids%0d: %h/%h/%h/%0d required %h/%h/%h/%0d", it, i, r_mfg[i], r_prod[i], r_serial[i], r_size[i], c_mfg[i], c_prod[i], c_serial[i], c_code[i]); fails++;
        end tests++;
        if (c_st[i] !== (e_shut[i] ? 2 : 1) || (!e_shut[i] && c_base[i] !== e_base[i])) begin $display("FAIL rnd%0d_card%0d: state=%0d base=%h required shut=%b base=%h", it, i, c_st[i], c_base[i], e_shut[i], e_base[i]); fails++; end tests++;
      end
      if (e_n < n_cards) begin
        if (c_st[e_n] !== 0) begin $display("FAIL rnd%0d_untouched: card%0d state=%0d required 0", it, e_n, c_st[e_n]); fails++; end tests++;
      end
    end
  endtask

  initial begin
    n_cards = 0;
    test_reset();
    test_single_mem();
    test_io_chain();
    test_no_fit();
    test_align();
    test_write_timeout();
    test_reset_midcycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
